// File: rtl/return_address_stack.sv
// Speculative return-address stack for the fetch front end, with a checkpoint FIFO
// that lets an early branch flush roll the stack pointer and count back.
module return_address_stack #(
    parameter int DEPTH       = 8,
    parameter int CHECKPOINTS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] new_addr,
    input  logic        pop,
    input  logic        branch_fetched,
    input  logic        branch_retired,
    input  logic        early_branch_flush,
    output logic [31:0] addr,
    output logic        valid,
    output logic        ckpt_full
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = IDX_W + 1;
    localparam int CP_W  = (CHECKPOINTS > 1) ? $clog2(CHECKPOINTS) : 1;
    localparam int OCC_W = CP_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(CHECKPOINTS);

    // Return addresses; asynchronous read, never reset.
    logic [31:0]      stack_q [DEPTH];
    logic [IDX_W-1:0] ckpt_idx_q [CHECKPOINTS];
    logic [CNT_W-1:0] ckpt_cnt_q [CHECKPOINTS];

    logic [IDX_W-1:0] read_index_q, read_index_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CP_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CP_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             ckpt_full_q, ckpt_full_d;

    logic             stack_we;
    logic [IDX_W-1:0] stack_waddr;
    logic             enq;
    logic             deq;

    assign enq = branch_fetched && !ckpt_full_q && !early_branch_flush;
    assign deq = branch_retired && (occ_q != '0) && !early_branch_flush;

    always_comb begin
        read_index_d = read_index_q;
        count_d      = count_q;
        stack_we     = 1'b0;
        stack_waddr  = read_index_q;

        if (early_branch_flush) begin
            if (occ_q != '0) begin
                read_index_d = ckpt_idx_q[rd_ptr_q];
                count_d      = ckpt_cnt_q[rd_ptr_q];
            end
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    stack_we     = 1'b1;
                    stack_waddr  = read_index_q + IDX_W'(1);
                    read_index_d = read_index_q + IDX_W'(1);
                    // Full stack wraps and drops the oldest entry.
                    if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
                end
                2'b01: begin
                    if (count_q != '0) begin
                        read_index_d = read_index_q - IDX_W'(1);
                        count_d      = count_q - CNT_W'(1);
                    end
                end
                2'b11: begin
                    // Tail call replaces the top entry in place.
                    stack_we = 1'b1;
                    if (count_q == '0) count_d = CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (early_branch_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + CP_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + CP_W'(1);
            unique case ({enq, deq})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
        ckpt_full_d = (occ_d == OCC_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_index_q <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            ckpt_full_q  <= 1'b0;
        end else begin
            read_index_q <= read_index_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            ckpt_full_q  <= ckpt_full_d;
        end
    end

    // Storage arrays carry no reset; writes are still blocked during reset.
    always_ff @(posedge clk) begin
        if (stack_we && !rst) stack_q[stack_waddr] <= new_addr;
        if (enq && !rst) begin
            ckpt_idx_q[wr_ptr_q] <= read_index_q;
            ckpt_cnt_q[wr_ptr_q] <= count_q;
        end
    end

    assign valid     = (count_q != '0);
    assign addr      = valid ? stack_q[read_index_q] : 32'h0;
    assign ckpt_full = ckpt_full_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Directed bench for return_address_stack (DEPTH=8, CHECKPOINTS=8).
module tb_return_address_stack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0;
    logic [31:0] new_addr = 32'h0;
    logic        pop = 1'b0;
    logic        branch_fetched = 1'b0;
    logic        branch_retired = 1'b0;
    logic        early_branch_flush = 1'b0;
    logic [31:0] addr;
    logic        valid;
    logic        ckpt_full;

    int n_checks = 0;
    int n_fail   = 0;

    return_address_stack #(.DEPTH(8), .CHECKPOINTS(8)) dut (
        .clk(clk), .rst(rst), .push(push), .new_addr(new_addr), .pop(pop),
        .branch_fetched(branch_fetched), .branch_retired(branch_retired),
        .early_branch_flush(early_branch_flush),
        .addr(addr), .valid(valid), .ckpt_full(ckpt_full)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; outputs are stable 1ns after the edge.
    task automatic cyc(input logic p, input logic [31:0] a, input logic po,
                       input logic bf, input logic br, input logic fl);
        push = p; new_addr = a; pop = po;
        branch_fetched = bf; branch_retired = br; early_branch_flush = fl;
        @(posedge clk); #1;
        push = 0; pop = 0; branch_fetched = 0; branch_retired = 0; early_branch_flush = 0;
    endtask

    task automatic do_reset();
        rst = 1; @(posedge clk); #1; rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; @(posedge clk); @(posedge clk); #1; rst = 0;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
        n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", addr); end
        n_checks++; if (ckpt_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", ckpt_full); end
    endtask

    task automatic test_push_pop();
        cyc(1, 32'h100, 0, 0, 0, 0);
        cyc(1, 32'h200, 0, 0, 0, 0);
        cyc(1, 32'h300, 0, 0, 0, 0);
        n_checks++; if (addr !== 32'h300) begin n_fail++; $display("FAIL pp_top got=%h exp=300", addr); end
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL pp_valid got=%b exp=1", valid); end
        n_checks++; if (dut.count_q !== 4'd3) begin n_fail++; $display("FAIL pp_count got=%0d exp=3", dut.count_q); end
        cyc(0, 0, 1, 0, 0, 0);
        n_checks++; if (addr !== 32'h200) begin n_fail++; $display("FAIL pp_pop1 got=%h exp=200", addr); end
        cyc(0, 0, 1, 0, 0, 0);
        n_checks++; if (addr !== 32'h100) begin n_fail++; $display("FAIL pp_pop2 got=%h exp=100", addr); end
        cyc(0, 0, 1, 0, 0, 0);
        n_checks++; if (addr !== 32'h0 || valid !== 1'b0) begin n_fail++; $display("FAIL pp_pop3 got=%h/%b exp=0/0", addr, valid); end
        cyc(0, 0, 1, 0, 0, 0);
        n_checks++; if (dut.count_q !== 4'd0 || valid !== 1'b0) begin n_fail++; $display("FAIL pp_pop_empty count=%0d valid=%b exp=0/0", dut.count_q, valid); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) cyc(1, 32'h10 * i, 0, 0, 0, 0);
        n_checks++; if (dut.count_q !== 4'd8) begin n_fail++; $display("FAIL ovf_count got=%0d exp=8", dut.count_q); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (addr !== 32'h90 - 32'h10 * i) begin n_fail++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, addr, 32'h90 - 32'h10 * i); end
            cyc(0, 0, 1, 0, 0, 0);
        end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got=%b exp=0", valid); end
    endtask

    task automatic test_tail_call();
        cyc(1, 32'h100, 0, 0, 0, 0);
        cyc(1, 32'h200, 1, 0, 0, 0);
        n_checks++; if (addr !== 32'h200) begin n_fail++; $display("FAIL tc_addr got=%h exp=200", addr); end
        n_checks++; if (dut.count_q !== 4'd1) begin n_fail++; $display("FAIL tc_count got=%0d exp=1", dut.count_q); end
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 32'h500, 1, 0, 0, 0);
        n_checks++; if (addr !== 32'h500 || dut.count_q !== 4'd1) begin n_fail++; $display("FAIL tc_empty got=%h/%0d exp=500/1", addr, dut.count_q); end
        cyc(0, 0, 1, 0, 0, 0);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL tc_drain got=%b exp=0", valid); end
    endtask

    task automatic test_flush_rollback();
        cyc(1, 32'h100, 0, 0, 0, 0);
        cyc(1, 32'h200, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 32'h300, 0, 0, 0, 0);
        n_checks++; if (addr !== 32'h300) begin n_fail++; $display("FAIL fl_spec got=%h exp=300", addr); end
        cyc(0, 0, 0, 0, 0, 1);
        n_checks++; if (addr !== 32'h200 || dut.count_q !== 4'd2) begin n_fail++; $display("FAIL fl_restore got=%h/%0d exp=200/2", addr, dut.count_q); end
        n_checks++; if (dut.occ_q !== 4'd0) begin n_fail++; $display("FAIL fl_occ got=%0d exp=0", dut.occ_q); end
        // Flush with empty FIFO keeps state and drops the push.
        cyc(1, 32'h999, 0, 1, 0, 1);
        n_checks++; if (addr !== 32'h200 || dut.count_q !== 4'd2 || dut.occ_q !== 4'd0) begin n_fail++; $display("FAIL fl_empty got=%h/%0d/%0d exp=200/2/0", addr, dut.count_q, dut.occ_q); end
        // Checkpoint captures the pre-push state.
        cyc(1, 32'h400, 0, 1, 0, 0);
        n_checks++; if (addr !== 32'h400 || dut.count_q !== 4'd3) begin n_fail++; $display("FAIL fl_bfpush got=%h/%0d exp=400/3", addr, dut.count_q); end
        cyc(0, 0, 0, 0, 0, 1);
        n_checks++; if (addr !== 32'h200 || dut.count_q !== 4'd2) begin n_fail++; $display("FAIL fl_preupd got=%h/%0d exp=200/2", addr, dut.count_q); end
    endtask

    task automatic test_ckpt_full();
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 32'h300, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0);
        n_checks++; if (ckpt_full !== 1'b0) begin n_fail++; $display("FAIL cf_seven got=%b exp=0", ckpt_full); end
        cyc(0, 0, 0, 1, 0, 0);
        n_checks++; if (ckpt_full !== 1'b1) begin n_fail++; $display("FAIL cf_full got=%b exp=1", ckpt_full); end
        cyc(0, 0, 0, 1, 0, 0);
        n_checks++; if (ckpt_full !== 1'b1 || dut.occ_q !== 4'd8) begin n_fail++; $display("FAIL cf_ignored got=%b/%0d exp=1/8", ckpt_full, dut.occ_q); end
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        n_checks++; if (addr !== 32'h100) begin n_fail++; $display("FAIL cf_pops got=%h exp=100", addr); end
        cyc(0, 0, 0, 0, 1, 0);
        n_checks++; if (ckpt_full !== 1'b0 || dut.occ_q !== 4'd7) begin n_fail++; $display("FAIL cf_retire got=%b/%0d exp=0/7", ckpt_full, dut.occ_q); end
        cyc(0, 0, 0, 0, 0, 1);
        n_checks++; if (addr !== 32'h300 || dut.count_q !== 4'd3) begin n_fail++; $display("FAIL cf_flush got=%h/%0d exp=300/3", addr, dut.count_q); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(0, 0, 0, 0, 1, 0);
        n_checks++; if (dut.occ_q !== 4'd0 || ckpt_full !== 1'b0) begin n_fail++; $display("FAIL bb_retire_empty got=%0d/%b exp=0/0", dut.occ_q, ckpt_full); end
        cyc(1, 32'h11, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 32'h22, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        n_checks++; if (dut.occ_q !== 4'd1) begin n_fail++; $display("FAIL bb_occ got=%0d exp=1", dut.occ_q); end
        cyc(1, 32'h33, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        n_checks++; if (addr !== 32'h22 || dut.count_q !== 4'd2) begin n_fail++; $display("FAIL bb_flush got=%h/%0d exp=22/2", addr, dut.count_q); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1, 32'h1, 0, 1, 0, 0);
        cyc(1, 32'h2, 0, 1, 0, 0);
        cyc(1, 32'h3, 0, 1, 0, 0);
        cyc(1, 32'h4, 0, 0, 0, 0);
        cyc(1, 32'h5, 0, 0, 0, 0);
        n_checks++; if (dut.count_q !== 4'd5 || dut.occ_q !== 4'd3 || addr !== 32'h5) begin n_fail++; $display("FAIL rm_setup got=%0d/%0d/%h exp=5/3/5", dut.count_q, dut.occ_q, addr); end
        rst = 1; push = 1; new_addr = 32'h77; branch_fetched = 1;
        @(posedge clk); #1;
        rst = 0; push = 0; branch_fetched = 0;
        n_checks++; if (valid !== 1'b0 || addr !== 32'h0 || ckpt_full !== 1'b0) begin n_fail++; $display("FAIL rm_outputs got=%b/%h/%b exp=0/0/0", valid, addr, ckpt_full); end
        n_checks++; if (dut.occ_q !== 4'd0) begin n_fail++; $display("FAIL rm_occ got=%0d exp=0", dut.occ_q); end
        cyc(0, 0, 1, 0, 0, 0);
        n_checks++; if (valid !== 1'b0 || dut.count_q !== 4'd0) begin n_fail++; $display("FAIL rm_pop got=%b/%0d exp=0/0", valid, dut.count_q); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_tail_call();
        test_flush_rollback();
        test_ckpt_full();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
